// File: rtl/dual_grant_scheduler_if.sv
// Bundle of request/release inputs and dual-slot grant outputs for dual_grant_scheduler.
// The master side drives requests; the slave side is the scheduler.
interface dual_grant_scheduler_if #(
  parameter int N    = 12,
  parameter int IDXW = 4
);
  logic [N-1:0]    req;
  logic [N-1:0]    done;
  logic [N-1:0]    gnt;
  logic            g0_valid;
  logic [IDXW-1:0] g0_idx;
  logic            g1_valid;
  logic [IDXW-1:0] g1_idx;
  logic [1:0]      tmo;

  modport master (
    output req, done,
    input  gnt, g0_valid, g0_idx, g1_valid, g1_idx, tmo
  );

  modport slave (
    input  req, done,
    output gnt, g0_valid, g0_idx, g1_valid, g1_idx, tmo
  );
endinterface

// File: rtl/dual_grant_scheduler.sv
// Two-slot grant scheduler: picks the next one or two pending requesters in rotating or fixed
// priority order and holds each grant until the owner releases it or the busy timeout expires.
module dual_grant_scheduler #(
  parameter int N    = 12,
  parameter int IDXW = 4,
  parameter int TMO  = 15,
  parameter int RR   = 1
) (
  input  logic clk,
  input  logic reset,
  dual_grant_scheduler_if.slave bus
);

  localparam int CW = $clog2(TMO + 1);

  if (IDXW < $clog2(N)) begin : gIdxwCheck
    $error("dual_grant_scheduler: IDXW too small for N");
  end
  if (TMO < 2) begin : gTmoCheck
    $error("dual_grant_scheduler: TMO must be at least 2");
  end

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } slotState_e;

  slotState_e             state_q [2];
  slotState_e             state_d [2];
  logic [1:0][CW-1:0]     cnt_q, cnt_d;
  logic [1:0][IDXW-1:0]   idx_q, idx_d;
  logic [1:0]             tmo_q, tmo_d;
  logic [N-1:0]           gnt_q, gnt_d;
  logic [IDXW-1:0]        ptr_q, ptr_d;

  logic [N-1:0]           cand;
  logic                   firstFound, secondFound;
  logic [IDXW-1:0]        firstIdx, secondIdx;
  logic [IDXW-1:0]        scanIdx;
  int                     pos;
  logic [1:0]             grant;
  logic [1:0][IDXW-1:0]   grantIdx;
  logic [IDXW-1:0]        lowIdx;

  // Walk the priority order ptr, ptr-1, ... (wrapping) and pick the first two pending requesters.
  always_comb begin
    cand        = bus.req & ~gnt_q;
    firstFound  = 1'b0;
    secondFound = 1'b0;
    firstIdx    = '0;
    secondIdx   = '0;
    pos         = 0;
    scanIdx     = '0;
    for (int k = 0; k < N; k++) begin
      pos = int'(ptr_q) - k;
      if (pos < 0) pos = pos + N;
      scanIdx = IDXW'(pos);
      if (cand[scanIdx]) begin
        if (!firstFound) begin
          firstFound = 1'b1;
          firstIdx   = scanIdx;
        end else if (!secondFound) begin
          secondFound = 1'b1;
          secondIdx   = scanIdx;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < 2; s++) state_q[s] <= IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      tmo_q <= '0;
      gnt_q <= '0;
      ptr_q <= IDXW'(N - 1);
    end else begin
      for (int s = 0; s < 2; s++) state_q[s] <= state_d[s];
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      tmo_q <= tmo_d;
      gnt_q <= gnt_d;
      ptr_q <= ptr_d;
    end
  end

  // Only slots idle before the edge take new work; slot 1 gets the runner-up when both are free.
  always_comb begin
    grant[0]    = (state_q[0] == IDLE) && firstFound;
    grantIdx[0] = firstIdx;
    grant[1]    = (state_q[1] == IDLE) &&
                  ((state_q[0] == IDLE) ? secondFound : firstFound);
    grantIdx[1] = (state_q[0] == IDLE) ? secondIdx : firstIdx;

    for (int s = 0; s < 2; s++) begin
      state_d[s] = state_q[s];
      cnt_d[s]   = cnt_q[s];
      idx_d[s]   = idx_q[s];
      tmo_d[s]   = 1'b0;
      case (state_q[s])
        IDLE: begin
          if (grant[s]) begin
            state_d[s] = BUSY;
            cnt_d[s]   = '0;
            idx_d[s]   = grantIdx[s];
          end
        end
        BUSY: begin
          if (bus.done[idx_q[s]]) begin
            state_d[s] = IDLE;
          end else if (cnt_q[s] == CW'(TMO - 1)) begin
            state_d[s] = IDLE;
            tmo_d[s]   = 1'b1;
          end else begin
            cnt_d[s] = cnt_q[s] + CW'(1);
          end
        end
        default: state_d[s] = IDLE;
      endcase
    end

    // The lowest-priority index granted this edge becomes the new top priority minus one.
    lowIdx = grant[1] ? grantIdx[1] : grantIdx[0];
    ptr_d  = ptr_q;
    if (RR == 0) begin
      ptr_d = IDXW'(N - 1);
    end else if (grant != 2'b00) begin
      ptr_d = (lowIdx == '0) ? IDXW'(N - 1) : (lowIdx - IDXW'(1));
    end

    gnt_d = '0;
    for (int i = 0; i < N; i++) begin
      gnt_d[i] = ((state_d[0] == BUSY) && (idx_d[0] == IDXW'(i))) ||
                 ((state_d[1] == BUSY) && (idx_d[1] == IDXW'(i)));
    end
  end

  always_comb begin
    bus.gnt      = gnt_q;
    bus.g0_valid = (state_q[0] == BUSY);
    bus.g0_idx   = idx_q[0];
    bus.g1_valid = (state_q[1] == BUSY);
    bus.g1_idx   = idx_q[1];
    bus.tmo      = tmo_q;
  end

endmodule

// File: tb/tb_dual_grant_scheduler.sv
// Directed scoreboard bench for dual_grant_scheduler: one rotating-priority and one fixed-priority
// instance, each exercised in its own phase while the other is held in reset.
module tb_dual_grant_scheduler;

  localparam int N    = 12;
  localparam int IDXW = 4;

  logic clk = 1'b0;
  logic resetA, resetB;

  always #5 clk = ~clk;

  dual_grant_scheduler_if #(.N(N), .IDXW(IDXW)) busA ();
  dual_grant_scheduler_if #(.N(N), .IDXW(IDXW)) busB ();

  dual_grant_scheduler #(.N(N), .IDXW(IDXW), .TMO(15), .RR(1)) dutA (
    .clk   (clk),
    .reset (resetA),
    .bus   (busA)
  );

  dual_grant_scheduler #(.N(N), .IDXW(IDXW), .TMO(15), .RR(0)) dutB (
    .clk   (clk),
    .reset (resetB),
    .bus   (busB)
  );

  typedef struct {
    string           tag;
    bit              dut;
    logic [N-1:0]    gnt;
    logic            v0;
    logic [IDXW-1:0] i0;
    logic            v1;
    logic [IDXW-1:0] i1;
    logic [1:0]      tmo;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic checkOutput();
    exp_t            e;
    logic [N-1:0]    og;
    logic            ov0, ov1;
    logic [IDXW-1:0] oi0, oi1;
    logic [1:0]      ot;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("[TB] FAIL scoreboard_empty: observed 0 entries, expected at least 1");
      return;
    end
    e = sb.pop_front();
    if (e.dut) begin
      og = busB.gnt; ov0 = busB.g0_valid; oi0 = busB.g0_idx;
      ov1 = busB.g1_valid; oi1 = busB.g1_idx; ot = busB.tmo;
    end else begin
      og = busA.gnt; ov0 = busA.g0_valid; oi0 = busA.g0_idx;
      ov1 = busA.g1_valid; oi1 = busA.g1_idx; ot = busA.tmo;
    end
    checks++;
    assert (og === e.gnt) else begin
      errors++;
      $error("[TB] FAIL %s.gnt: observed %03h expected %03h", e.tag, og, e.gnt);
    end
    checks++;
    assert (ov0 === e.v0) else begin
      errors++;
      $error("[TB] FAIL %s.g0_valid: observed %b expected %b", e.tag, ov0, e.v0);
    end
    checks++;
    assert (oi0 === e.i0) else begin
      errors++;
      $error("[TB] FAIL %s.g0_idx: observed %0d expected %0d", e.tag, oi0, e.i0);
    end
    checks++;
    assert (ov1 === e.v1) else begin
      errors++;
      $error("[TB] FAIL %s.g1_valid: observed %b expected %b", e.tag, ov1, e.v1);
    end
    checks++;
    assert (oi1 === e.i1) else begin
      errors++;
      $error("[TB] FAIL %s.g1_idx: observed %0d expected %0d", e.tag, oi1, e.i1);
    end
    checks++;
    assert (ot === e.tmo) else begin
      errors++;
      $error("[TB] FAIL %s.tmo: observed %b expected %b", e.tag, ot, e.tmo);
    end
  endtask

  // Drive one cycle of stimulus on the selected instance, queue its expected outputs, then check.
  task automatic applyStimulus(input string tag, input bit dut, input bit rst,
                               input logic [N-1:0] req, input logic [N-1:0] done,
                               input logic [N-1:0] gnt, input logic v0, input logic [IDXW-1:0] i0,
                               input logic v1, input logic [IDXW-1:0] i1, input logic [1:0] tmo);
    exp_t e;
    if (dut) begin
      resetB = rst; busB.req = req; busB.done = done;
      resetA = 1'b1; busA.req = '0; busA.done = '0;
    end else begin
      resetA = rst; busA.req = req; busA.done = done;
      resetB = 1'b1; busB.req = '0; busB.done = '0;
    end
    e.tag = tag; e.dut = dut; e.gnt = gnt; e.v0 = v0; e.i0 = i0;
    e.v1 = v1; e.i1 = i1; e.tmo = tmo;
    sb.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  // Structural invariants on both instances, sampled mid-cycle.
  always @(negedge clk) begin
    checks++;
    assert (!(busA.g0_valid && busA.g1_valid) || (busA.g0_idx !== busA.g1_idx)) else begin
      errors++;
      $error("[TB] FAIL invA_idx: observed g0_idx=%0d g1_idx=%0d expected distinct", busA.g0_idx, busA.g1_idx);
    end
    checks++;
    assert ($countones(busA.gnt) === (int'(busA.g0_valid) + int'(busA.g1_valid))) else begin
      errors++;
      $error("[TB] FAIL invA_pop: observed popcount %0d expected %0d", $countones(busA.gnt), int'(busA.g0_valid) + int'(busA.g1_valid));
    end
    checks++;
    assert (!(busB.g0_valid && busB.g1_valid) || (busB.g0_idx !== busB.g1_idx)) else begin
      errors++;
      $error("[TB] FAIL invB_idx: observed g0_idx=%0d g1_idx=%0d expected distinct", busB.g0_idx, busB.g1_idx);
    end
    checks++;
    assert ($countones(busB.gnt) === (int'(busB.g0_valid) + int'(busB.g1_valid))) else begin
      errors++;
      $error("[TB] FAIL invB_pop: observed popcount %0d expected %0d", $countones(busB.gnt), int'(busB.g0_valid) + int'(busB.g1_valid));
    end
  end

  initial begin
    resetA = 1'b1; resetB = 1'b1;
    busA.req = '0; busA.done = '0;
    busB.req = '0; busB.done = '0;
    $display("[TB] starting dual_grant_scheduler bench");

    // Rotating priority: dual grant, release, refill, wrap-around, persistence.
    applyStimulus("A_reset",     0, 1, 12'h000, 12'h000, 12'h000, 0, 0,  0, 0,  2'b00);
    applyStimulus("T1_grant",    0, 0, 12'hAAA, 12'h000, 12'hA00, 1, 11, 1, 9,  2'b00);
    applyStimulus("T1_hold",     0, 0, 12'hAAA, 12'h000, 12'hA00, 1, 11, 1, 9,  2'b00);
    applyStimulus("T2_done11",   0, 0, 12'hAAA, 12'h800, 12'h200, 0, 11, 1, 9,  2'b00);
    applyStimulus("T2_regrant",  0, 0, 12'hAAA, 12'h000, 12'h280, 1, 7,  1, 9,  2'b00);
    applyStimulus("done_stray",  0, 0, 12'hAAA, 12'h020, 12'h280, 1, 7,  1, 9,  2'b00);
    applyStimulus("done_both",   0, 0, 12'hAAA, 12'h280, 12'h000, 0, 7,  0, 9,  2'b00);
    applyStimulus("rr_53",       0, 0, 12'hAAA, 12'h000, 12'h028, 1, 5,  1, 3,  2'b00);
    applyStimulus("done_53",     0, 0, 12'hAAA, 12'h028, 12'h000, 0, 5,  0, 3,  2'b00);
    applyStimulus("rr_wrap",     0, 0, 12'hAAA, 12'h000, 12'h802, 1, 1,  1, 11, 2'b00);
    applyStimulus("done_slot1",  0, 0, 12'hAAA, 12'h800, 12'h002, 1, 1,  0, 11, 2'b00);
    applyStimulus("slot1_only",  0, 0, 12'hAAA, 12'h000, 12'h202, 1, 1,  1, 9,  2'b00);
    applyStimulus("req_drop",    0, 0, 12'h000, 12'h000, 12'h202, 1, 1,  1, 9,  2'b00);
    applyStimulus("T6_reset",    0, 1, 12'h000, 12'h000, 12'h000, 0, 0,  0, 0,  2'b00);
    applyStimulus("T6_idle1",    0, 0, 12'h000, 12'h000, 12'h000, 0, 0,  0, 0,  2'b00);
    applyStimulus("T6_idle2",    0, 0, 12'h000, 12'h000, 12'h000, 0, 0,  0, 0,  2'b00);

    // Single requester: timeout after 15 busy cycles, one idle cycle, regrant.
    applyStimulus("T3_grant",    0, 0, 12'h010, 12'h000, 12'h010, 1, 4,  0, 0,  2'b00);
    for (int c = 0; c < 14; c++)
      applyStimulus("T4_busy",   0, 0, 12'h010, 12'h000, 12'h010, 1, 4,  0, 0,  2'b00);
    applyStimulus("T4_timeout",  0, 0, 12'h010, 12'h000, 12'h000, 0, 4,  0, 0,  2'b01);
    applyStimulus("T4_regrant",  0, 0, 12'h010, 12'h000, 12'h010, 1, 4,  0, 0,  2'b00);
    for (int c = 0; c < 14; c++)
      applyStimulus("T4_busy2",  0, 0, 12'h010, 12'h000, 12'h010, 1, 4,  0, 0,  2'b00);
    applyStimulus("done_vs_tmo", 0, 0, 12'h010, 12'h010, 12'h000, 0, 4,  0, 0,  2'b00);
    applyStimulus("after_done",  0, 0, 12'h010, 12'h000, 12'h010, 1, 4,  0, 0,  2'b00);

    // Both slots time out on the same edge.
    applyStimulus("A_reset2",    0, 1, 12'h030, 12'h000, 12'h000, 0, 0,  0, 0,  2'b00);
    applyStimulus("dual_grant",  0, 0, 12'h030, 12'h000, 12'h030, 1, 5,  1, 4,  2'b00);
    for (int c = 0; c < 14; c++)
      applyStimulus("dual_busy", 0, 0, 12'h030, 12'h000, 12'h030, 1, 5,  1, 4,  2'b00);
    applyStimulus("dual_tmo",    0, 0, 12'h030, 12'h000, 12'h000, 0, 5,  0, 4,  2'b11);
    applyStimulus("dual_regrnt", 0, 0, 12'h030, 12'h000, 12'h030, 1, 5,  1, 4,  2'b00);

    // Fixed priority: every round yields indices 10 and 7.
    applyStimulus("B_reset",     1, 1, 12'h000, 12'h000, 12'h000, 0, 0,  0, 0,  2'b00);
    applyStimulus("T5_grant",    1, 0, 12'h49A, 12'h000, 12'h480, 1, 10, 1, 7,  2'b00);
    applyStimulus("T5_done",     1, 0, 12'h49A, 12'h480, 12'h000, 0, 10, 0, 7,  2'b00);
    applyStimulus("T5_grant2",   1, 0, 12'h49A, 12'h000, 12'h480, 1, 10, 1, 7,  2'b00);
    applyStimulus("T5_done7",    1, 0, 12'h49A, 12'h080, 12'h400, 1, 10, 0, 7,  2'b00);
    applyStimulus("T5_grant3",   1, 0, 12'h49A, 12'h000, 12'h480, 1, 10, 1, 7,  2'b00);
    applyStimulus("T5_done10",   1, 0, 12'h49A, 12'h400, 12'h080, 0, 10, 1, 7,  2'b00);
    applyStimulus("T5_grant4",   1, 0, 12'h49A, 12'h000, 12'h480, 1, 10, 1, 7,  2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
